// File: rtl/pow2.sv
// Fixed-point 2^x: three-stage pipeline (split, shift/overflow, saturate)
// with a single global advance enable driven by downstream backpressure.
module pow2 #(
  parameter int Bf              = 8,
  parameter int FIX_POINT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FIX_POINT_WIDTH-1:0] in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FIX_POINT_WIDTH-1:0] out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       ovf
);

  localparam int W  = FIX_POINT_WIDTH;
  localparam int KW = W - Bf;
  localparam int MW = Bf + 1;

  // Largest integer exponent whose shifted mantissa still fits in W bits.
  localparam logic signed [KW-1:0] K_MAX   = KW'(W - Bf - 1);
  localparam logic        [KW:0]   SH_ZERO = (KW + 1)'(MW);

  logic en;

  logic                 v1;
  logic signed [KW-1:0] k1;
  logic [MW-1:0]        m1;

  logic          v2;
  logic [W-1:0]  r2;
  logic          ovf2;

  logic [KW-1:0] k_pos;
  logic [KW:0]   k_neg;
  logic [W-1:0]  shifted;
  logic          big;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      k1 <= '0;
      m1 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      k1 <= in[W-1:Bf];
      m1 <= {1'b1, in[Bf-1:0]};
    end
  end

  // Magnitude of a negative exponent; one extra bit so the most negative k negates cleanly.
  assign k_pos = $unsigned(k1);
  assign k_neg = -{k1[KW-1], k1};

  always_comb begin
    shifted = '0;
    big     = 1'b0;
    if (!k1[KW-1]) begin
      if (k1 > K_MAX) big = 1'b1;
      else            shifted = W'(m1) << k_pos;
    end else if (k_neg < SH_ZERO) begin
      shifted = W'(m1) >> k_neg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      r2   <= '0;
      ovf2 <= 1'b0;
    end else if (en) begin
      v2   <= v1;
      r2   <= shifted;
      ovf2 <= big;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      out       <= ovf2 ? '1 : r2;
      ovf       <= ovf2;
    end
  end

endmodule

// File: tb/tb_pow2.sv
// Self-checking bench for pow2 (Bf=8, W=16): directed value/latency cases,
// streaming, backpressure, mid-stream reset and a long randomized run.
module tb_pow2;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  logic [16:0] q[$];
  logic        hold;
  logic [15:0] hold_out;
  logic        hold_ovf;
  logic [16:0] exp_v;

  logic b2b_on;
  int   b2b_cyc, b2b_cnt, b2b_first, b2b_last;

  pow2 #(.Bf(8), .FIX_POINT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 2^x with x = k + f/256, mantissa approximated as 1 + f/256.
  function automatic logic [16:0] model(input logic [15:0] x);
    int xi, k, m;
    logic [15:0] r;
    logic        o;
    xi = int'($signed(x));
    k  = xi >>> 8;
    m  = 256 + (xi & 255);
    o  = 1'b0;
    if (k > 7) begin
      r = 16'hFFFF;
      o = 1'b1;
    end else if (k >= 0) begin
      r = 16'(m << k);
    end else if (-k >= 9) begin
      r = 16'h0000;
    end else begin
      r = 16'(m >> (-k));
    end
    return {o, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: push on acceptance, pop and compare on every consumed result.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_out", 32'(out), 32'(hold_out));
        check("hold_ovf", 32'(ovf), 32'(hold_ovf));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_v = q.pop_front();
          check("stream_out", 32'(out), 32'(exp_v[15:0]));
          check("stream_ovf", 32'(ovf), 32'(exp_v[16]));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in));
      hold     = out_valid && !out_ready;
      hold_out = out;
      hold_ovf = ovf;
    end
  end

  always @(negedge clk) begin
    if (!b2b_on) begin
      b2b_cyc   = 0;
      b2b_cnt   = 0;
      b2b_first = -1;
      b2b_last  = -1;
    end else begin
      if (out_valid) begin
        if (b2b_first < 0) b2b_first = b2b_cyc;
        b2b_last = b2b_cyc;
        b2b_cnt++;
      end
      b2b_cyc++;
    end
  end

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [15:0] x, input logic [15:0] eo, input logic eovf);
    check("model_pin", 32'(model(x)), 32'({eovf, eo}));
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    in       = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_c1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_c2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    check("lat_c3_out", 32'(out), 32'(eo));
    check("lat_c3_ovf", 32'(ovf), 32'(eovf));
  endtask

  initial begin
    rst       = 1'b0;
    in        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    b2b_on    = 1'b0;
    hold      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;

    run_one(16'h0000, 16'h0100, 1'b0);
    run_one(16'h0100, 16'h0200, 1'b0);
    run_one(16'h0080, 16'h0180, 1'b0);
    run_one(16'hFF00, 16'h0080, 1'b0);
    run_one(16'hF800, 16'h0001, 1'b0);
    run_one(16'h0700, 16'h8000, 1'b0);
    run_one(16'h07FF, 16'hFF80, 1'b0);
    run_one(16'h0800, 16'hFFFF, 1'b1);
    run_one(16'h7FFF, 16'hFFFF, 1'b1);
    run_one(16'h8000, 16'h0000, 1'b0);
    run_one(16'hF700, 16'h0000, 1'b0);
    drain();

    // Back-to-back stream of 10
    b2b_on    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in       = 16'(int'($urandom_range(0, 4096)) - 2048);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_count", 32'(b2b_cnt), 32'd10);
    check("b2b_contig", 32'(b2b_last - b2b_first + 1), 32'd10);
    b2b_on = 1'b0;
    drain();

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = 16'($urandom);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      in = 16'($urandom);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_queued", 32'(q.size()), 32'd3);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset mid-stream with three samples in flight
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = 16'(int'($urandom_range(0, 2048)) - 1024);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    run_one(16'h0180, 16'h0300, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) in = 16'($urandom);
      else                           in = 16'(int'($urandom_range(0, 5120)) - 2560);
      @(posedge clk);
      #1;
    end
    drain();
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pow2.md
POW2 -- requirements
Module: pow2

Interface
REQ-001 Parameter Bf, default 8, number of fractional bits of input and output fixed-point words.
REQ-002 Parameter FIX_POINT_WIDTH, default 16, total width W of input and output words; Bf < W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst==0 resets).
REQ-005 in  input  W  signed two's-complement exponent x, Q(W-Bf).Bf, i.e. log2-domain value from the upstream log2 stage.
REQ-006 in_valid  input  1  in holds a valid sample this cycle.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out  output  W  unsigned result 2^x, Q(W-Bf).Bf.
REQ-009 out_valid  output  1  out/ovf hold a valid result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 ovf  output  1  result saturated, qualified by out_valid.

Function
REQ-012 Arithmetic: k = floor(x) = in >>> Bf (arithmetic); f = in[Bf-1:0]; mantissa m = {1'b1, f} (Bf+1 bits, value 1+f/2^Bf, first-order 2^f approximation).
REQ-013 k >= 0: result = m << k; k < 0: result = m >> (-k), truncated toward zero, shifts of Bf+1 or more give 0.
REQ-014 Saturation: if k > W-Bf-1, out = all ones and ovf = 1; otherwise ovf = 0 and out = result (always fits in W bits).
REQ-015 Pipeline: 3 register stages S1 (capture in, split k/m), S2 (shift, overflow detect), S3 (saturate, drive out/ovf/out_valid).
REQ-016 Global advance enable en = ~out_valid | out_ready; in_ready = en (combinational).
REQ-017 Sample accepted on rising edge when in_valid & in_ready; each stage carries its own valid bit.
REQ-018 Latency exactly 3 cycles from acceptance edge to out_valid high when out_ready held 1; throughput 1 sample/cycle.
REQ-019 en == 0: all stage registers and valid bits hold; out, ovf stable while out_valid & ~out_ready.
REQ-020 Bubbles (in_valid low while en) propagate as invalid stages; no reordering, no loss, no duplication.
REQ-021 Simultaneous out_valid & out_ready & new acceptance: result leaves and pipeline shifts in the same edge.
REQ-022 out and ovf are don't-care when out_valid == 0 but SHALL be deterministic (registered, no X after reset).
REQ-023 Most negative input (0x8000 at W=16) gives out = 0, ovf = 0.

Reset
REQ-024 rst low asynchronously clears all stage valid bits, out = 0, ovf = 0, out_valid = 0, independent of clk.
REQ-025 in_ready = 1 during and after reset (pipeline empty).
REQ-026 Reset asserted mid-operation discards all in-flight samples; first result after release comes only from samples accepted after release.
REQ-027 Release of rst synchronous to design use; no sample accepted on an edge where rst is low.

Verification (Bf=8, W=16)
REQ-028 Basic values, out_ready=1: in 0x0000->0x0100, 0x0100->0x0200, 0x0080->0x0180, 0xFF00->0x0080, 0xF800->0x0001, each 3 cycles after acceptance, ovf=0.
REQ-029 Range edges: 0x0700->0x8000 ovf=0; 0x07FF->0xFF80 ovf=0; 0x0800->0xFFFF ovf=1; 0x7FFF->0xFFFF ovf=1; 0x8000->0x0000 ovf=0.
REQ-030 Back-to-back stream of 10 samples with out_ready=1: 10 consecutive out_valid cycles, correct order and values.
REQ-031 Backpressure: fill pipeline, drop out_ready for 5 cycles -> in_ready=0, out/ovf stable, no loss; on out_ready=1 remaining results emerge in order.
REQ-032 Reset mid-stream: rst low with 3 samples in flight -> out_valid=0 immediately, no stale results after release.
REQ-033 Random test: 10k random in with random in_valid/out_ready, results match REQ-012..014 reference model with scoreboard ordering.
